mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Data-side initiator for the word-addressed unified memory of the multicycle RISC-V core.
- Sits between the core's control/datapath and the memory, which has a combinational read, a synchronous write on `WrEn` and word index `Addr[31:2]`.
- Converts one load/store request (lb/lh/lw/lbu/lhu/sb/sh/sw) into memory cycles.
- Sub-word stores use read-modify-write, because the memory has no byte enables.
- Reports completion with a one-cycle `done` pulse and classifies faults.

Parameters:
- `MEM_WORDS`, 64, number of 32-bit words in the memory. A word index ≥ `MEM_WORDS` is out of range.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  1  request strobe; sampled only when `busy`=0.
- `we`  in  1  1=store, 0=load; sampled with `req`.
- `funct3`  in  3  RISC-V width/sign field; sampled with `req`.
- `addr`  in  32  byte address; sampled with `req`.
- `wdata`  in  32  store data (low byte/half used for sb/sh); sampled with `req`.
- `busy`  out  1  1 whenever state ≠ IDLE.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  32  load result, extended to 32 bits; held until the next completed load.
- `fault`  out  2  00 none, 01 misaligned, 10 out of range, 11 illegal `funct3`; valid with `done`, held until the next `done`.
- `MemAddr`  out  32  to memory `Addr`.
- `MemWrEn`  out  1  to memory `WrEn`.
- `MemWriteData`  out  32  to memory `WriteData`.
- `MemReadData`  in  32  from memory `ReadData` (combinational).

Behaviour:
- Reset values: state=IDLE, `busy`=0, `done`=0, `rdata`=0, `fault`=00, `MemAddr`=0, `MemWrEn`=0, `MemWriteData`=0. Captured request registers clear to 0.
- `MemWrEn` is gated by `~reset`. No memory write occurs on any cycle in which `reset`=1, including reset asserted mid read-modify-write; the memory word stays unmodified.
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- IDLE: on `req`=1, capture `we`/`funct3`/`addr`/`wdata` and decode.
  - Fault check, priority illegal > misaligned > out of range:
    - Illegal: load `funct3` ∈ {011,110,111}; store `funct3` ∉ {000,001,010}.
    - Misaligned: halfword with `addr[0]`=1; word with `addr[1:0]`≠0.
    - Out of range: `addr[31:2]` ≥ `MEM_WORDS`.
  - Fault → RESP with `fault` set and no memory access.
  - Otherwise: load → LOAD; sw → STORE; sb/sh → RMW_RD.
  - `req`=0 → stay in IDLE.
- LOAD:
  - Drive `MemAddr={addr_q[31:2],2'b00}`.
  - Register the extracted lane of `MemReadData` into `rdata`:
    - Byte lane selected by `addr_q[1:0]`; halfword lane by `addr_q[1]`.
    - Sign-extend for lb/lh; zero-extend for lbu/lhu; lw takes the full word.
  - Next: RESP.
- STORE: `MemAddr` as in LOAD, `MemWrEn`=1, `MemWriteData=wdata_q`. Next: RESP.
- RMW_RD: drive `MemAddr`; latch `MemReadData` into a merge register. Next: RMW_WR.
- RMW_WR:
  - `MemWrEn`=1; `MemWriteData` = latched word with the selected byte (sb, `wdata_q[7:0]`) or halfword (sh, `wdata_q[15:0]`) replaced; other bytes unchanged.
  - Next: RESP.
- RESP: `done`=1 for exactly this cycle; `fault` updated (00 on success). Next: IDLE.
- Latency, with `req` accepted at edge T (`done` high during the cycle after edge):
  - Fault: `done` at T+1.
  - Load and sw: `done` at T+2.
  - sb/sh: `done` at T+3.
- `req` while `busy`=1, including the RESP cycle, is ignored and not queued.
- In IDLE and RESP, `MemAddr`=0 and `MemWrEn`=0.
- A store never changes `rdata`. A faulted load leaves `rdata` unchanged.
- Back-to-back: `req` held high continuously starts a new access on the first IDLE cycle after RESP.

Test Plan:
1. Preload word 2 (0x8)=0x80F07F01.
   - lb 0x9 → `rdata`=0x0000007F at T+2.
   - lb 0xA → 0xFFFFFFF0.
   - lbu 0xA → 0x000000F0.
   - lh 0xA → 0xFFFF80F0.
   - lhu 0xA → 0x000080F0.
   - lw 0x8 → 0x80F07F01.
   - `fault`=00 for all.
2. sb 0x9, `wdata`=0x00000123 → single `MemWrEn` pulse at `MemAddr`=0x8 with data 0x80F02301; `done` at T+3. Follow with sh 0xE, `wdata`=0xBEEF on word 3 (=0x11223344) → 0xBEEF3344.
3. sw 0x6 → `fault`=01, `done` at T+1, `MemWrEn` never asserted. lh 0x5 → 01. Load with `funct3`=011 at 0x6 → 11 (illegal outranks misaligned).
4. lw 0x100 with `MEM_WORDS`=64 → `fault`=10, no access. lw 0xFC → success.
5. `reset` high during the RMW_WR cycle of sb 0x8 → no write; memory word unchanged; outputs at reset values next cycle; a following lw completes normally.
6. `req` held high across two sw requests (0x0, 0x4) → second accepted only after RESP; two `done` pulses 3 cycles apart; `req` pulsed during `busy` produces no extra access.

Source files
------------

// File: rtl/mem_access_unit.sv
// Data-side load/store initiator for a word-addressed memory with combinational read.
// Sub-word stores are done as read-modify-write because the memory has no byte enables.
module mem_access_unit #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic [1:0]  fault,
    output logic [31:0] MemAddr,
    output logic        MemWrEn,
    output logic [31:0] MemWriteData,
    input  logic [31:0] MemReadData
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] STORE  = 3'd2;
    localparam logic [2:0] RMW_RD = 3'd3;
    localparam logic [2:0] RMW_WR = 3'd4;
    localparam logic [2:0] RESP   = 3'd5;

    logic [2:0]  state;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;

    logic        illegal;
    logic        misaligned;
    logic        out_of_range;
    logic [1:0]  req_fault;
    logic [31:0] load_data;
    logic [31:0] merge_data;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Decode of the incoming request; illegal outranks misaligned outranks out of range.
    always_comb begin
        if (we)
            illegal = (funct3 > 3'b010);
        else
            illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        misaligned   = ((funct3[1:0] == 2'b01) && addr[0]) ||
                       ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        out_of_range = ({2'b00, addr[31:2]} >= 32'(MEM_WORDS));
        if (illegal)
            req_fault = 2'b11;
        else if (misaligned)
            req_fault = 2'b01;
        else if (out_of_range)
            req_fault = 2'b10;
        else
            req_fault = 2'b00;
    end

    always_comb begin
        byte_lane = 8'(MemReadData >> {addr_q[1:0], 3'b000});
        half_lane = addr_q[1] ? MemReadData[31:16] : MemReadData[15:0];
        case (funct3_q[1:0])
            2'b00:   load_data = funct3_q[2] ? {24'd0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            2'b01:   load_data = funct3_q[2] ? {16'd0, half_lane} : {{16{half_lane[15]}}, half_lane};
            default: load_data = MemReadData;
        endcase
    end

    // Splice the store byte/halfword into the word read during RMW_RD.
    always_comb begin
        merge_data = merge_q;
        if (funct3_q[1:0] == 2'b00)
            merge_data[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else if (addr_q[1])
            merge_data[31:16] = wdata_q[15:0];
        else
            merge_data[15:0] = wdata_q[15:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            merge_q  <= 32'd0;
            rdata    <= 32'd0;
            fault    <= 2'b00;
        end else begin
            case (state)
                IDLE: if (req) begin
                    we_q     <= we;
                    funct3_q <= funct3;
                    addr_q   <= addr;
                    wdata_q  <= wdata;
                    if (req_fault != 2'b00) begin
                        fault <= req_fault;
                        state <= RESP;
                    end else if (!we)
                        state <= LOAD;
                    else if (funct3 == 3'b010)
                        state <= STORE;
                    else
                        state <= RMW_RD;
                end
                LOAD: begin
                    rdata <= load_data;
                    fault <= 2'b00;
                    state <= RESP;
                end
                STORE: begin
                    fault <= 2'b00;
                    state <= RESP;
                end
                RMW_RD: begin
                    merge_q <= MemReadData;
                    state   <= RMW_WR;
                end
                RMW_WR: begin
                    fault <= 2'b00;
                    state <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The reset gate on the write strobe keeps an interrupted RMW from corrupting memory.
    always_comb begin
        busy         = (state != IDLE);
        done         = (state == RESP);
        MemAddr      = 32'd0;
        MemWrEn      = 1'b0;
        MemWriteData = 32'd0;
        if (state == LOAD || state == STORE || state == RMW_RD || state == RMW_WR)
            MemAddr = {addr_q[31:2], 2'b00};
        if (state == STORE) begin
            MemWrEn      = ~reset;
            MemWriteData = wdata_q;
        end else if (state == RMW_WR) begin
            MemWrEn      = ~reset;
            MemWriteData = merge_data;
        end
    end

    logic unused_we_q;
    assign unused_we_q = we_q;

endmodule
